// File: rtl/tinytpu_ctrl.sv
// Phase sequencer for the TinyTPU systolic datapath: operand load, array feed, result serialization.
// Optional LOAD watchdog enabled by defining TINYTPU_CTRL_LOAD_TIMEOUT_EN.
module tinytpu_ctrl #(
   parameter int D_W = 8,
   parameter int N = 2,
   parameter int ACC_W = 2 * D_W + $clog2(N),
   localparam int IDX_W = $clog2(N * N),
   localparam int STEP_W = $clog2(3 * N - 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              init,
   input  logic              load_en,
   output logic              shift_en,
   output logic              word_we,
   output logic [IDX_W-1:0]  word_idx,
   output logic              pe_clr,
   output logic              feed_en,
   output logic [STEP_W-1:0] feed_step,
   output logic [IDX_W-1:0]  res_sel,
   output logic              tx_load,
   output logic              tx_ready,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int BIT_W = (D_W > 1) ? $clog2(D_W) : 1;
   localparam int TXB_W = (ACC_W > 1) ? $clog2(ACC_W) : 1;
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(D_W - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N * N - 1);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(3 * N - 2);
   localparam logic [TXB_W-1:0]  TXB_LAST  = TXB_W'(ACC_W - 1);

   typedef enum logic [2:0] {IDLE, CLEAR, LOAD, COMPUTE, TX_LD, TX_SH, DONE} state_e;

   state_e            state_q, state_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic [IDX_W-1:0]  widx_q, widx_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic [IDX_W-1:0]  rsel_q, rsel_d;
   logic [TXB_W-1:0]  txb_q, txb_d;
`ifdef TINYTPU_CTRL_LOAD_TIMEOUT_EN
   logic              err_q, err_d;
   logic [7:0]        idle_q, idle_d;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         bit_q   <= '0;
         widx_q  <= '0;
         step_q  <= '0;
         rsel_q  <= '0;
         txb_q   <= '0;
`ifdef TINYTPU_CTRL_LOAD_TIMEOUT_EN
         err_q   <= 1'b0;
         idle_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         bit_q   <= bit_d;
         widx_q  <= widx_d;
         step_q  <= step_d;
         rsel_q  <= rsel_d;
         txb_q   <= txb_d;
`ifdef TINYTPU_CTRL_LOAD_TIMEOUT_EN
         err_q   <= err_d;
         idle_q  <= idle_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      bit_d    = bit_q;
      widx_d   = widx_q;
      step_d   = step_q;
      rsel_d   = rsel_q;
      txb_d    = txb_q;
      shift_en = 1'b0;
      word_we  = 1'b0;
`ifdef TINYTPU_CTRL_LOAD_TIMEOUT_EN
      err_d    = err_q;
      idle_d   = idle_q;
`endif
      case (state_q)
         IDLE: ;
         CLEAR: begin
            bit_d   = '0;
            widx_d  = '0;
            step_d  = '0;
            state_d = LOAD;
         end
         LOAD: begin
            if (load_en) begin
               shift_en = 1'b1;
`ifdef TINYTPU_CTRL_LOAD_TIMEOUT_EN
               idle_d   = '0;
`endif
               if (bit_q == BIT_LAST) begin
                  word_we = 1'b1;
                  bit_d   = '0;
                  if (widx_q == IDX_LAST) begin
                     widx_d  = '0;
                     state_d = COMPUTE;
                  end else begin
                     widx_d = widx_q + IDX_W'(1);
                  end
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end
`ifdef TINYTPU_CTRL_LOAD_TIMEOUT_EN
            // The watchdog only arms once the first operand bit has arrived.
            else if (bit_q != '0 || widx_q != '0) begin
               if (idle_q == 8'd254) begin
                  state_d = IDLE;
                  err_d   = 1'b1;
                  idle_d  = '0;
                  bit_d   = '0;
                  widx_d  = '0;
               end else begin
                  idle_d = idle_q + 8'd1;
               end
            end
`endif
         end
         COMPUTE: begin
            if (step_q == STEP_LAST) begin
               step_d  = '0;
               rsel_d  = '0;
               state_d = TX_LD;
            end else begin
               step_d = step_q + STEP_W'(1);
            end
         end
         TX_LD: begin
            txb_d   = '0;
            state_d = TX_SH;
         end
         TX_SH: begin
            if (txb_q == TXB_LAST) begin
               txb_d = '0;
               if (rsel_q == IDX_LAST) begin
                  state_d = DONE;
               end else begin
                  rsel_d  = rsel_q + IDX_W'(1);
                  state_d = TX_LD;
               end
            end else begin
               txb_d = txb_q + TXB_W'(1);
            end
         end
         DONE: begin
            rsel_d  = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // A start strobe restarts from CLEAR in every state and discards any partial word.
      if (init) begin
         state_d  = CLEAR;
         bit_d    = '0;
         widx_d   = '0;
         step_d   = '0;
         rsel_d   = '0;
         txb_d    = '0;
         shift_en = 1'b0;
         word_we  = 1'b0;
`ifdef TINYTPU_CTRL_LOAD_TIMEOUT_EN
         err_d    = 1'b0;
         idle_d   = '0;
`endif
      end
   end

   assign word_idx  = widx_q;
   assign feed_step = step_q;
   assign res_sel   = rsel_q;
   assign pe_clr    = (state_q == CLEAR);
   assign feed_en   = (state_q == COMPUTE);
   assign tx_load   = (state_q == TX_LD);
   assign tx_ready  = (state_q == TX_SH);
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
`ifdef TINYTPU_CTRL_LOAD_TIMEOUT_EN
   assign err       = err_q;
`else
   assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_tinytpu_ctrl.sv
// Self-checking bench for tinytpu_ctrl: expected per-cycle strobes are derived from the
// load schedule with plain arithmetic (phase lengths and cycle offsets), not from state machines.
module tb_tinytpu_ctrl;

   localparam int D_W     = 8;
   localparam int N       = 2;
   localparam int ACC_W   = 2 * D_W + $clog2(N);
   localparam int NW      = N * N;
   localparam int STEPS   = 3 * N - 1;
   localparam int WORDCYC = 1 + ACC_W;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       init;
   logic       load_en;
   logic       shift_en, word_we, pe_clr, feed_en, tx_load, tx_ready, busy, done, err;
   logic [1:0] word_idx;
   logic [2:0] feed_step;
   logic [1:0] res_sel;

   int nCompared   = 0;
   int nMismatched = 0;
   int curT        = 0;

   tinytpu_ctrl #(.D_W(D_W), .N(N)) dut (
      .clk(clk), .rst_n(rst_n), .init(init), .load_en(load_en),
      .shift_en(shift_en), .word_we(word_we), .word_idx(word_idx),
      .pe_clr(pe_clr), .feed_en(feed_en), .feed_step(feed_step),
      .res_sel(res_sel), .tx_load(tx_load), .tx_ready(tx_ready),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] ctlVec();
      return {shift_en, word_we, pe_clr, feed_en, tx_load, tx_ready, busy, done, err};
   endfunction

   // Inputs change well after the rising edge; outputs are sampled before the next one.
   task automatic applyStimulus(input logic iV, input logic lV);
      init    = iV;
      load_en = lV;
      #2;
   endtask

   task automatic nextEdge();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
      nCompared++;
      assert (got === exp) else begin
         nMismatched++;
         $error("[TB] FAIL %s t=%0d observed=%h expected=%h", tag, curT, got, exp);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput(tag, {ctlVec(), word_idx, feed_step, res_sel}, 16'h0000);
   endtask

   // One full job: t=0 is the init cycle in IDLE, t=1 CLEAR, LOAD follows the generated
   // load_en schedule, then fixed-length COMPUTE and transmit phases end in a done pulse.
   task automatic runTransaction(input int gapMode, input bit skipInit, input int abortOff);
      bit le[$];
      int ones;
      int c, tDone, tEnd, tAbort;
      le = {};
      ones = 0;
      case (gapMode)
         0: repeat (D_W * NW) le.push_back(1'b1);
         1: for (int k = 0; k < D_W * NW; k++) begin
               le.push_back(1'b1);
               if (k < D_W * NW - 1) repeat (3) le.push_back(1'b0);
            end
         2: while (ones < D_W * NW) begin
               bit b;
               b = ($urandom_range(0, 2) != 0);
               le.push_back(b);
               ones += int'(b);
            end
         default: begin
            repeat (10) le.push_back(1'b1);
            repeat (255) le.push_back(1'b0);
            repeat (D_W * NW - 10) le.push_back(1'b1);
         end
      endcase
      c      = 2 + le.size();
      tDone  = c + STEPS + NW * WORDCYC;
      tEnd   = tDone + 3;
      tAbort = (abortOff >= 0) ? c + STEPS + 2 * WORDCYC + 1 + abortOff : -1;
      ones   = 0;
      for (int t = (skipInit ? 1 : 0); t <= tEnd; t++) begin
         logic       iV, lV;
         logic [8:0] e;
         int         u;
         curT = t;
         iV = (t == 0) || (t == tAbort);
         if (t >= 2 && t < c) lV = le[t - 2];
         else lV = 1'($urandom_range(0, 1));
         applyStimulus(iV, lV);
         e = '0;
         e[2] = (t >= 1 && t <= tDone);
         if (t == 1) e[6] = 1'b1;
         if (t >= 2 && t < c && lV) begin
            e[8] = 1'b1;
            ones++;
            if (ones % D_W == 0) e[7] = 1'b1;
         end
         if (t >= c && t < c + STEPS) e[5] = 1'b1;
         u = t - c - STEPS;
         if (u >= 0 && u < NW * WORDCYC) begin
            if (u % WORDCYC == 0) e[4] = 1'b1;
            else e[3] = 1'b1;
         end
         if (t == tDone) e[1] = 1'b1;
         checkOutput("ctl", {7'b0, ctlVec()}, {7'b0, e});
         if (e[7]) checkOutput("word_idx", {14'b0, word_idx}, 16'(ones / D_W - 1));
         if (e[5]) checkOutput("feed_step", {13'b0, feed_step}, 16'(t - c));
         if (e[4] | e[3]) checkOutput("res_sel", {14'b0, res_sel}, 16'(u / WORDCYC));
         if (t == 1) checkOutput("clr_res_sel", {14'b0, res_sel}, 16'h0000);
         nextEdge();
         if (t == tAbort) return;
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      init    = 1'b0;
      load_en = 1'b0;

      // Reset held while the start and load inputs toggle.
      for (int k = 0; k < 6; k++) begin
         curT = k;
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         checkAllZero("reset");
         nextEdge();
      end
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         curT = k;
         applyStimulus(1'b0, 1'($urandom_range(0, 1)));
         checkAllZero("idle");
         nextEdge();
      end

      $display("[TB] contiguous load");
      runTransaction(0, 1'b0, -1);
      $display("[TB] gapped load 1 on 3 off");
      runTransaction(1, 1'b0, -1);
      $display("[TB] random gapped load");
      runTransaction(2, 1'b0, -1);
      $display("[TB] abort during word 2 transmit, then restart");
      runTransaction(0, 1'b0, 1 + int'($urandom_range(0, 14)));
      runTransaction(2, 1'b1, -1);

      // Asynchronous reset in the middle of LOAD.
      $display("[TB] reset mid-operation");
      applyStimulus(1'b1, 1'b0);
      nextEdge();
      repeat (15) begin
         applyStimulus(1'b0, 1'b1);
         nextEdge();
      end
      rst_n = 1'b0;
      #1;
      curT = 0;
      checkAllZero("async_rst");
      nextEdge();
      for (int k = 0; k < 3; k++) begin
         curT = k;
         applyStimulus(1'($urandom_range(0, 1)), 1'b1);
         checkAllZero("rst_hold");
         nextEdge();
      end
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         curT = k;
         applyStimulus(1'b0, 1'($urandom_range(0, 1)));
         checkAllZero("post_rst");
         nextEdge();
      end

`ifdef TINYTPU_CTRL_LOAD_TIMEOUT_EN
      $display("[TB] load watchdog enabled");
      applyStimulus(1'b1, 1'b0);
      nextEdge();
      applyStimulus(1'b0, 1'b0);
      nextEdge();
      repeat (10) begin
         applyStimulus(1'b0, 1'b1);
         nextEdge();
      end
      for (int k = 0; k < 255; k++) begin
         curT = k;
         applyStimulus(1'b0, 1'b0);
         if (k == 0 || k == 254) checkOutput("to_wait", {14'b0, busy, err}, 16'h0002);
         nextEdge();
      end
      applyStimulus(1'b0, 1'b0);
      checkOutput("to_err", {14'b0, busy, err}, 16'h0001);
      nextEdge();
      applyStimulus(1'b1, 1'b0);
      checkOutput("err_sticky", {14'b0, busy, err}, 16'h0001);
      nextEdge();
      runTransaction(0, 1'b1, -1);
`else
      $display("[TB] load stall without watchdog");
      runTransaction(3, 1'b0, -1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/tinytpu_ctrl.md
# tinytpu_ctrl

Sequencing controller for the TinyTPU systolic datapath. It frames the bit-serial x/y operand load, clears and steps the N×N PE array through its skewed feed schedule, then drives the result serializer word by word. It sits between the top-level pins (`init`, `load_en`, `tx_ready`) and the datapath, and owns all phase control.

## Interface
- `D_W`, 8, operand width in bits
- `N`, 2, array dimension (N×N PEs, N×N words per operand matrix)
- `ACC_W`, 2*D_W+$clog2(N), result word width
- derived: `IDX_W`=$clog2(N*N), `STEP_W`=$clog2(3*N-1)

Ports:
- `clk` in 1: sole clock, rising edge
- `rst_n` in 1: asynchronous active-low reset
- `init` in 1: start/restart strobe
- `load_en` in 1: serial operand bit valid on x/y lines this cycle
- `shift_en` out 1: deserializer shift strobe
- `word_we` out 1: commit assembled x/y word pair
- `word_idx` out IDX_W: row-major element index for `word_we`
- `pe_clr` out 1: clear all PE accumulators
- `feed_en` out 1: advance array one skew step
- `feed_step` out STEP_W: current skew step
- `res_sel` out IDX_W: result element presented to serializer
- `tx_load` out 1: parallel-load serializer from `res_sel`
- `tx_ready` out 1: serial output bit valid (serializer shifts on it)
- `busy` out 1: not IDLE
- `done` out 1: one-cycle completion pulse
- `err` out 1: sticky load timeout flag

## Operation
- States: IDLE, CLEAR, LOAD, COMPUTE, TX_LD, TX_SH, DONE.
- IDLE: `init`=1 -> CLEAR; `err` cleared.
- CLEAR (1 cycle): `pe_clr`=1; bit/word/step counters zeroed -> LOAD.
- LOAD: `shift_en` = `load_en` (combinational). `bit_cnt` increments per `load_en` cycle, wraps at D_W-1; on the wrap cycle `word_we`=1 (combinational) with `word_idx`=current word, then `word_idx` increments. After word N*N-1 commits -> COMPUTE. `load_en`=0 pauses; counters hold.
- COMPUTE: `feed_en`=1 for 3N-1 cycles, `feed_step` 0..3N-2; after last step -> TX_LD with `res_sel`=0.
- TX_LD (1 cycle): `tx_load`=1. -> TX_SH.
- TX_SH: `tx_ready`=1 for ACC_W cycles (LSB first). Then if `res_sel`=N*N-1 -> DONE, else `res_sel`+1 -> TX_LD.
- DONE (1 cycle): `done`=1 -> IDLE.
- `init` in any non-IDLE state: abort, -> CLEAR next cycle (highest priority).
- `load_en` outside LOAD: ignored, `shift_en`/`word_we` stay 0.

## Timing
- Reset: state IDLE; all counters, `res_sel`, `word_idx`, `feed_step` = 0; every output 0.
- All outputs except `shift_en`, `word_we` are Moore decodes of registered state/counters.
- `init` at edge k -> `pe_clr` during cycle k+1, LOAD from k+2.
- Load: exactly D_W*N*N `load_en` cycles (32 at defaults); COMPUTE starts the cycle after the final `word_we`.
- Total from LOAD exit to `done`: (3N-1) + N*N*(1+ACC_W) + 1 cycles (5+72+1=78 at defaults).
- Reset mid-operation: immediate return to IDLE, outputs 0, no `done`.

## Configuration
- `TINYTPU_CTRL_LOAD_TIMEOUT_EN` defined: in LOAD, after ≥1 bit received, 255 consecutive cycles with `load_en`=0 -> IDLE with `err`=1 (sticky until next `init` or reset). Idle counter resets on any `load_en`.
- Undefined: LOAD waits indefinitely; `err` tied 0; no timeout counter.

## Test plan
- Reset with `init`/`load_en` toggling -> all outputs 0, `busy`=0 until first `init`.
- `init`, then 32 contiguous `load_en` -> `pe_clr` 1 cycle; `word_we` at load cycles 8,16,24,32 with `word_idx` 0,1,2,3; `feed_en` 5 cycles, `feed_step` 0..4.
- Full run -> 4× (`tx_load` 1 cycle + `tx_ready` 17 cycles), `res_sel` 0..3, `done` 78 cycles after COMPUTE entry, then `busy`=0.
- `load_en` gapped (1 on, 3 off) -> identical `word_we`/`word_idx` sequence, only stretched; no extra strobes.
- `init` during TX_SH of word 2 -> next cycle CLEAR, `tx_ready`=0, `res_sel`=0, no `done`.
- With macro: 10 bits loaded then `load_en` low 255 cycles -> IDLE, `err`=1; next `init` clears `err`. Without macro: stays in LOAD, `err`=0.
